// File: rtl/dpcm_pkg.sv
// Shared types and sample constants for the DPCM encoder/decoder datapath.
package dpcm_pkg;

  localparam int SAMPLE_W   = 8;
  localparam int SAMPLE_MIN = 0;
  localparam int SAMPLE_MAX = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUM  = 2'd1,
    S_OUT  = 2'd2
  } dpcm_state_t;

endpackage

// File: rtl/dpcm_decoder_if.sv
// Stream and debug signals of the DPCM decoder; master drives differences and
// consumes samples, slave is the decoder itself.
interface dpcm_decoder_if #(
  parameter int SAT_CNT_W = 16
);
  import dpcm_pkg::*;

  logic [SAMPLE_W-1:0]  in_diff;
  logic                 in_sync;
  logic                 in_valid;
  logic                 in_ready;
  logic [SAMPLE_W-1:0]  out_sample;
  logic                 out_valid;
  logic                 out_ready;
  logic [SAT_CNT_W-1:0] sat_count;
  logic [1:0]           out_state;

  modport master (
    output in_diff, in_sync, in_valid, out_ready,
    input  in_ready, out_sample, out_valid, sat_count, out_state
  );

  modport slave (
    input  in_diff, in_sync, in_valid, out_ready,
    output in_ready, out_sample, out_valid, sat_count, out_state
  );
endinterface

// File: rtl/dpcm_clamp.sv
// Clamps a 10-bit signed reconstruction sum into the unsigned sample range and
// flags whenever clamping took place.
module dpcm_clamp
  import dpcm_pkg::*;
(
  input  logic signed [9:0]          sum_i,
  output logic        [SAMPLE_W-1:0] value_o,
  output logic                       sat_o
);

  always_comb begin
    value_o = sum_i[SAMPLE_W-1:0];
    sat_o   = 1'b0;
    if (sum_i < SAMPLE_MIN) begin
      value_o = SAMPLE_W'(SAMPLE_MIN);
      sat_o   = 1'b1;
    end else if (sum_i > SAMPLE_MAX) begin
      value_o = SAMPLE_W'(SAMPLE_MAX);
      sat_o   = 1'b1;
    end
  end

endmodule

// File: rtl/dpcm_decoder.sv
// DPCM receive side: accepts a signed difference, adds it to the last emitted
// sample (or 0 on frame sync), clamps, and emits it over valid/ready.
module dpcm_decoder
  import dpcm_pkg::*;
#(
  parameter int SAT_CNT_W = 16
) (
  input logic           clk,
  input logic           reset,
  dpcm_decoder_if.slave bus
);

  dpcm_state_t          state_q, state_d;
  logic [SAMPLE_W-1:0]  pred_q, pred_d;
  logic [SAMPLE_W-1:0]  diff_q, diff_d;
  logic                 sync_q, sync_d;
  logic [SAMPLE_W-1:0]  sample_q, sample_d;
  logic [SAT_CNT_W-1:0] sat_count_q, sat_count_d;

  logic [SAMPLE_W-1:0]  base;
  logic signed [9:0]    sum;
  logic [SAMPLE_W-1:0]  clamp_value;
  logic                 clamp_sat;

  // Base is zero-extended and the difference sign-extended, so 10 bits cover -128..382.
  assign base = sync_q ? '0 : pred_q;
  assign sum  = signed'({2'b00, base}) + signed'({{2{diff_q[SAMPLE_W-1]}}, diff_q});

  dpcm_clamp u_clamp (
    .sum_i   (sum),
    .value_o (clamp_value),
    .sat_o   (clamp_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pred_q      <= '0;
      diff_q      <= '0;
      sync_q      <= 1'b0;
      sample_q    <= '0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      diff_q      <= diff_d;
      sync_q      <= sync_d;
      sample_q    <= sample_d;
      sat_count_q <= sat_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    diff_d      = diff_q;
    sync_d      = sync_q;
    sample_d    = sample_q;
    sat_count_d = sat_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          diff_d  = bus.in_diff;
          sync_d  = bus.in_sync;
          state_d = S_SUM;
        end
      end
      S_SUM: begin
        sample_d = clamp_value;
        if (clamp_sat && !(&sat_count_q)) begin
          sat_count_d = sat_count_q + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        // Prediction advances only once the sample is actually taken downstream.
        if (bus.out_ready) begin
          pred_d  = sample_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_OUT);
  assign bus.out_sample = sample_q;
  assign bus.sat_count  = sat_count_q;
  assign bus.out_state  = state_q;

endmodule
